// File: rtl/drv8874_ctrl.sv
// -----------------------------------------------------------------------------
// drv8874_ctrl
//
// Sequencer for one DRV8874 H-bridge in IN/IN mode. It takes direction, duty
// and decay commands over a valid/ready handshake. It generates an edge-aligned
// PWM whose period is 2^PWM_BITS-1 cycles. New settings take effect only at
// period boundaries, and every direction reversal is separated by a coast
// interval. The driver is woken and put to sleep under 'en'.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst        : synchronous, active-high reset
//   en         : 1 = run, 0 = put the driver to sleep
//   cmd_valid  : a command is present
//   cmd_ready  : a command can be accepted (pending slot empty)
//   cmd_dir    : 0 = forward (IN1 driven), 1 = reverse (IN2 driven)
//   cmd_duty   : on-cycles per period; 0 = off, all-ones = 100 %
//   cmd_slow   : off-phase decay; 1 = brake (1,1), 0 = coast (0,0)
//   in1, in2   : registered driver inputs
//   nsleep     : registered driver nSLEEP
//   state      : 0 SLEEP, 1 WAKE, 2 RUN, 3 DEAD
// -----------------------------------------------------------------------------
module drv8874_ctrl #(
   parameter int PWM_BITS    = 8,
   parameter int DEAD_CYCLES = 4,
   parameter int WAKE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_dir,
   input  logic [PWM_BITS-1:0] cmd_duty,
   input  logic                cmd_slow,
   output logic                in1,
   output logic                in2,
   output logic                nsleep,
   output logic [1:0]          state
);

   typedef enum logic [1:0] {
      SLEEP = 2'd0,
      WAKE  = 2'd1,
      RUN   = 2'd2,
      DEAD  = 2'd3
   } state_t;

   localparam int TMAX = (WAKE_CYCLES > DEAD_CYCLES) ? WAKE_CYCLES : DEAD_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   // Last count value of a period; the counter wraps to 0 after it.
   localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((2 ** PWM_BITS) - 2);

   state_t              st;
   logic                act_dir;
   logic                act_slow;
   logic [PWM_BITS-1:0] act_duty;
   logic                pend_dir;
   logic                pend_slow;
   logic [PWM_BITS-1:0] pend_duty;
   logic                pend_flag;
   logic [PWM_BITS-1:0] cnt;
   logic [TW-1:0]       timer;

   logic xfer;
   logic boundary;
   logic timer_last;

   assign state      = st;
   assign cmd_ready  = !pend_flag;
   assign xfer       = cmd_valid && cmd_ready;
   assign boundary   = (cnt == CNT_MAX);
   // The timer is loaded with the interval length and the state is left on
   // its final cycle, so WAKE and DEAD each last exactly their cycle count.
   assign timer_last = (timer <= TW'(1));

   // NOTE: every register here is state, so all assignments are non-blocking;
   // where two assignments to the same register could meet in one cycle, the
   // later one in this block wins, which the priority order below relies on.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the synchronous reset clears every register explicitly; there
         // is no storage array here that would be left uninitialised.
         st        <= SLEEP;
         act_dir   <= 1'b0;
         act_slow  <= 1'b0;
         act_duty  <= '0;
         pend_dir  <= 1'b0;
         pend_slow <= 1'b0;
         pend_duty <= '0;
         pend_flag <= 1'b0;
         cnt       <= '0;
         timer     <= '0;
         in1       <= 1'b0;
         in2       <= 1'b0;
         nsleep    <= 1'b0;
      end else begin
         // Pins are a registered function of the present state and count.
         if (st == RUN) begin
            if (cnt < act_duty) begin
               {in1, in2} <= act_dir ? 2'b01 : 2'b10;
            end else begin
               {in1, in2} <= act_slow ? 2'b11 : 2'b00;
            end
         end else begin
            {in1, in2} <= 2'b00;
         end
         nsleep <= (st != SLEEP);

         if (!en) begin
            // Sleep wins over reversal, boundary and transfer. Whatever the
            // latest command is becomes the active setting for the next wake.
            st        <= SLEEP;
            timer     <= '0;
            cnt       <= '0;
            pend_flag <= 1'b0;
            if (xfer) begin
               act_dir  <= cmd_dir;
               act_duty <= cmd_duty;
               act_slow <= cmd_slow;
            end else if (pend_flag) begin
               act_dir  <= pend_dir;
               act_duty <= pend_duty;
               act_slow <= pend_slow;
            end
         end else begin
            // Outside RUN/DEAD no PWM is running, so commands apply directly.
            if (xfer && (st == SLEEP || st == WAKE)) begin
               act_dir  <= cmd_dir;
               act_duty <= cmd_duty;
               act_slow <= cmd_slow;
            end
            if (xfer && (st == RUN || st == DEAD)) begin
               pend_dir  <= cmd_dir;
               pend_duty <= cmd_duty;
               pend_slow <= cmd_slow;
               pend_flag <= 1'b1;
            end

            case (st)
               SLEEP: begin
                  st    <= WAKE;
                  timer <= TW'(WAKE_CYCLES);
               end
               WAKE: begin
                  if (timer_last) begin
                     st    <= RUN;
                     cnt   <= '0;
                     timer <= '0;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               RUN: begin
                  if (boundary) begin
                     cnt <= '0;
                     // pend_flag is the value before this edge, so a command
                     // accepted on the boundary itself waits a full period.
                     if (pend_flag) begin
                        if (pend_dir == act_dir) begin
                           act_duty  <= pend_duty;
                           act_slow  <= pend_slow;
                           pend_flag <= 1'b0;
                        end else begin
                           st    <= DEAD;
                           timer <= TW'(DEAD_CYCLES);
                        end
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DEAD: begin
                  if (timer_last) begin
                     st        <= RUN;
                     cnt       <= '0;
                     timer     <= '0;
                     act_dir   <= pend_dir;
                     act_duty  <= pend_duty;
                     act_slow  <= pend_slow;
                     pend_flag <= 1'b0;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               default: st <= SLEEP;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_drv8874_ctrl.sv
// -----------------------------------------------------------------------------
// tb_drv8874_ctrl
//
// Directed bench for drv8874_ctrl with PWM_BITS = 4 (period 15),
// DEAD_CYCLES = 4 and WAKE_CYCLES = 8. Inputs change 1 ns after a rising edge,
// and outputs are sampled at the same point, so each sample shows the
// registers as they stand after the edge just passed.
// -----------------------------------------------------------------------------
module tb_drv8874_ctrl;

   localparam int PB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_dir;
   logic [PB-1:0] cmd_duty;
   logic          cmd_slow;
   logic          in1;
   logic          in2;
   logic          nsleep;
   logic [1:0]    state;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] S_SLEEP = 8'd0;
   localparam logic [7:0] S_WAKE  = 8'd1;
   localparam logic [7:0] S_RUN   = 8'd2;
   localparam logic [7:0] S_DEAD  = 8'd3;

   drv8874_ctrl #(
      .PWM_BITS   (PB),
      .DEAD_CYCLES(4),
      .WAKE_CYCLES(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_dir  (cmd_dir),
      .cmd_duty (cmd_duty),
      .cmd_slow (cmd_slow),
      .in1      (in1),
      .in2      (in2),
      .nsleep   (nsleep),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_pins(input string tag, input logic [1:0] exp);
      logic [7:0] o;
      logic [7:0] e;
      o = {6'd0, in1, in2};
      e = {6'd0, exp};
      check(tag, o, e);
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      logic [7:0] o;
      logic [7:0] e;
      o = {7'd0, obs};
      e = {7'd0, exp};
      check(tag, o, e);
   endtask

   task automatic check_state(input string tag, input logic [7:0] exp);
      logic [7:0] o;
      o = {6'd0, state};
      check(tag, o, exp);
   endtask

   // Advance n cycles, checking the pin pair after every edge.
   task automatic run_pins(input int n, input logic [1:0] exp, input string tag);
      for (int i = 0; i < n; i++) begin
         step();
         check_pins(tag, exp);
      end
   endtask

   task automatic set_cmd(input logic v, input logic d, input logic [PB-1:0] du, input logic s);
      cmd_valid = v;
      cmd_dir   = d;
      cmd_duty  = du;
      cmd_slow  = s;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      set_cmd(1'b0, 1'b0, 4'd0, 1'b0);
      step();
      step();
      rst = 1'b0;

      // Reset state
      check_state("rst_state", S_SLEEP);
      check_pins("rst_pins", 2'b00);
      check_bit("rst_nsleep", nsleep, 1'b0);
      check_bit("rst_ready", cmd_ready, 1'b1);

      // 1: wake with duty 5 forward accepted while asleep
      en = 1'b1;
      set_cmd(1'b1, 1'b0, 4'd5, 1'b0);
      step();
      check_state("s1_wake", S_WAKE);
      check_bit("s1_nsleep_lat", nsleep, 1'b0);
      check_bit("s1_ready_direct", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      step();
      check_bit("s1_nsleep_up", nsleep, 1'b1);
      check_pins("s1_wake_pins0", 2'b00);
      run_pins(7, 2'b00, "s1_wake_pins");
      run_pins(5, 2'b10, "s1_on_p1");
      run_pins(10, 2'b00, "s1_off_p1");
      run_pins(5, 2'b10, "s1_on_p2");
      run_pins(10, 2'b00, "s1_off_p2");

      // 2: duty 10 mid-period, same direction
      run_pins(3, 2'b10, "s2_on_old_a");
      check_bit("s2_ready_before", cmd_ready, 1'b1);
      set_cmd(1'b1, 1'b0, 4'd10, 1'b0);
      step();
      check_pins("s2_on_old_b", 2'b10);
      cmd_valid = 1'b0;
      check_bit("s2_ready_low", cmd_ready, 1'b0);
      run_pins(1, 2'b10, "s2_on_old_c");
      run_pins(9, 2'b00, "s2_off_old");
      check_bit("s2_ready_still_low", cmd_ready, 1'b0);
      run_pins(1, 2'b00, "s2_off_last");
      check_bit("s2_ready_up", cmd_ready, 1'b1);
      run_pins(10, 2'b10, "s2_on_new");
      run_pins(5, 2'b00, "s2_off_new");

      // 4: brake decay, duty 3 then duty 0
      set_cmd(1'b1, 1'b0, 4'd3, 1'b1);
      step();
      check_pins("s4_on_prev_a", 2'b10);
      cmd_valid = 1'b0;
      run_pins(9, 2'b10, "s4_on_prev");
      run_pins(5, 2'b00, "s4_off_prev");
      check_bit("s4_ready_up", cmd_ready, 1'b1);
      set_cmd(1'b1, 1'b0, 4'd0, 1'b1);
      step();
      check_pins("s4_on_d3_a", 2'b10);
      cmd_valid = 1'b0;
      run_pins(2, 2'b10, "s4_on_d3");
      run_pins(12, 2'b11, "s4_brake_d3");
      run_pins(15, 2'b11, "s4_brake_d0");

      // 3: forward 100 % then reverse 100 %
      set_cmd(1'b1, 1'b0, 4'd15, 1'b0);
      step();
      check_pins("s3_d0_a", 2'b11);
      cmd_valid = 1'b0;
      run_pins(14, 2'b11, "s3_d0");
      set_cmd(1'b1, 1'b1, 4'd15, 1'b0);
      step();
      check_pins("s3_fwd_a", 2'b10);
      cmd_valid = 1'b0;
      check_bit("s3_ready_low", cmd_ready, 1'b0);
      run_pins(14, 2'b10, "s3_fwd");
      check_state("s3_dead", S_DEAD);
      run_pins(4, 2'b00, "s3_coast");
      check_state("s3_run_again", S_RUN);
      check_bit("s3_ready_up", cmd_ready, 1'b1);
      run_pins(20, 2'b01, "s3_rev");

      // 5: drop en during DEAD with reverse pending, then re-enable
      rst = 1'b1;
      en  = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_state("s5_rst_state", S_SLEEP);
      check_pins("s5_rst_pins", 2'b00);
      en = 1'b1;
      set_cmd(1'b1, 1'b0, 4'd15, 1'b0);
      step();
      cmd_valid = 1'b0;
      run_pins(8, 2'b00, "s5_wake");
      check_state("s5_run", S_RUN);
      set_cmd(1'b1, 1'b1, 4'd15, 1'b0);
      step();
      check_pins("s5_fwd_a", 2'b10);
      cmd_valid = 1'b0;
      run_pins(14, 2'b10, "s5_fwd");
      check_state("s5_dead", S_DEAD);
      run_pins(1, 2'b00, "s5_dead_pins");
      en = 1'b0;
      step();
      check_state("s5_sleep", S_SLEEP);
      check_pins("s5_pins_edge1", 2'b00);
      check_bit("s5_ready_cleared", cmd_ready, 1'b1);
      step();
      check_bit("s5_nsleep_low", nsleep, 1'b0);
      check_pins("s5_pins_edge2", 2'b00);
      en = 1'b1;
      run_pins(9, 2'b00, "s5_rewake");
      check_bit("s5_nsleep_up", nsleep, 1'b1);
      check_state("s5_run_no_dead", S_RUN);
      run_pins(14, 2'b01, "s5_rev");

      // 6: command on the boundary cycle, then a second one while pending
      set_cmd(1'b1, 1'b1, 4'd5, 1'b0);
      check_bit("s6_ready_boundary", cmd_ready, 1'b1);
      step();
      check_pins("s6_boundary_pins", 2'b01);
      check_bit("s6_ready_low", cmd_ready, 1'b0);
      cmd_duty = 4'd9;
      cmd_slow = 1'b1;
      run_pins(14, 2'b01, "s6_old_period");
      check_bit("s6_ready_wait", cmd_ready, 1'b0);
      run_pins(1, 2'b01, "s6_old_last");
      check_bit("s6_ready_up", cmd_ready, 1'b1);
      step();
      check_pins("s6_d5_a", 2'b01);
      check_bit("s6_second_taken", cmd_ready, 1'b0);
      cmd_valid = 1'b0;
      run_pins(4, 2'b01, "s6_d5_on");
      run_pins(10, 2'b00, "s6_d5_coast");
      run_pins(9, 2'b01, "s6_d9_on");
      run_pins(6, 2'b11, "s6_d9_brake");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/drv8874_ctrl.md
# drv8874_ctrl

Sequencer for one DRV8874 H-bridge in IN/IN mode. It accepts direction, duty and decay-mode commands over a valid/ready handshake and drives the IN1/IN2/nSLEEP pins. It generates an edge-aligned PWM, applies new settings only at period boundaries, and inserts a coast interval on every direction reversal. It wakes and sleeps the driver under `en`. It replaces the fixed IN1/IN2 stimulus as the source for the driver model's inputs.

## Interface
- `PWM_BITS`, 8: duty/counter width; PWM period = 2^PWM_BITS − 1 clock cycles.
- `DEAD_CYCLES`, 4: coast cycles on direction reversal (≥1).
- `WAKE_CYCLES`, 16: cycles from nSLEEP rising to the first drive (≥1).

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: 1 = run, 0 = sleep driver.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted.
- `cmd_dir` in 1: 0 = forward (IN1 driven), 1 = reverse (IN2 driven).
- `cmd_duty` in PWM_BITS: on-cycles per period; 0 = off, all-ones = 100 %.
- `cmd_slow` in 1: off-phase decay; 1 = brake (1,1), 0 = coast (0,0).
- `in1`, `in2` out 1: driver inputs, registered.
- `nsleep` out 1: driver nSLEEP, registered.
- `state` out 2: 0 SLEEP, 1 WAKE, 2 RUN, 3 DEAD.

## Operation
- Registers: active {dir, duty, slow}; pending {dir, duty, slow, flag}; period counter `cnt` (0..2^PWM_BITS−2, wraps to 0); timer for WAKE/DEAD.
- Handshake: `cmd_ready = !pending_flag`. A transfer occurs when `cmd_valid & cmd_ready`. In SLEEP/WAKE a transfer writes the active registers directly. In RUN/DEAD it fills pending.
- Drive mapping:
  - RUN on-phase (`cnt < duty`): dir 0 → (1,0); dir 1 → (0,1).
  - RUN off-phase: slow → (1,1), else (0,0).
  - SLEEP, WAKE, DEAD: (0,0).
- FSM:
  - SLEEP: nsleep = 0. Goes to WAKE when `en` = 1; timer loads WAKE_CYCLES.
  - WAKE: nsleep = 1. Goes to RUN when the timer expires, with `cnt` = 0.
  - RUN: at the boundary cycle (`cnt` = max, about to wrap), if pending is set:
    - same dir: copy pending to active and clear pending; the new period starts with the new values.
    - different dir: go to DEAD, timer loads DEAD_CYCLES, and pending is not yet copied.
  - DEAD: when the timer expires, copy pending to active, clear pending, go to RUN with `cnt` = 0.
  - Any state: `en` = 0 goes to SLEEP on the next edge. If pending is set, it is copied to active and cleared; the timer and `cnt` are cleared.
- A transfer on the boundary cycle itself goes to pending and is applied at the next boundary, not the current one.
- Duty 0 always produces the off-phase. Duty all-ones always produces the on-phase.
- A direction change with either duty = 0 still takes the DEAD path.

## Timing
- Reset values:
  - state SLEEP.
  - in1 = in2 = 0, nsleep = 0.
  - cmd_ready = 1.
  - active dir = 0, duty = 0, slow = 0; pending flag = 0; cnt = 0; timer = 0.
- Outputs are registered. Pins reflect the state and `cnt` of the previous cycle, a fixed 1-cycle latency.
- nsleep rises 1 cycle after `en` is sampled high. The first on-phase pin change occurs WAKE_CYCLES + 1 cycles after that.
- Reversal produces exactly DEAD_CYCLES cycles of (0,0) between the last old-direction period and the first new-direction period. The state is never (1,0) adjacent to (0,1).
- `en` falling: pins are (0,0) and nsleep = 0 on the 2nd edge after `en` is sampled low. This takes priority over reversal, boundary and command transfer in the same cycle.
- `rst` overrides everything, including mid-DEAD and mid-WAKE.
- cmd_ready falls the cycle after a RUN/DEAD transfer. It rises the cycle after pending is applied.

## Test plan
All scenarios use PWM_BITS = 4 (period 15), DEAD_CYCLES = 4, WAKE_CYCLES = 8.

1. Reset, then `en` = 1 with cmd {dir 0, duty 5, slow 0} accepted in SLEEP → nsleep = 1 on the next cycle, (0,0) for the wake period, then repeating 5 cycles (1,0) / 10 cycles (0,0).
2. In RUN, send duty 10 with the same dir mid-period → old duty finishes the current period, the next period has 10 on-cycles, and cmd_ready is low until the boundary.
3. In RUN at dir 0 duty 15, send dir 1 duty 15 → 4 cycles of (0,0), then constant (0,1). No cycle shows (1,0) followed directly by (0,1).
4. slow = 1, duty 3 → each period is 3 cycles (1,0) and 12 cycles (1,1). duty 0 → constant (1,1).
5. Drop `en` during DEAD with pending dir 1 → pins (0,0) and nsleep = 0 within 2 edges. Re-enable → after wake, drive is in dir 1 with no DEAD interval.
6. Command presented on the boundary cycle, then a 2nd cmd_valid while pending → first command applies one period later; the second waits with cmd_ready = 0 and is accepted the cycle after.
